// File: rtl/match_result_collector.sv
// match_result_collector: buffers 10-bit match results from the match block
// wrapper in a FIFO. The control processor drains results and reads status
// and statistics counters over a small Avalon-MM slave. Freeze and enable
// gate only the accept path and the stall counter, never the stored data.
module match_result_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  mask_data_out,
    input  logic        mask_data_valid,
    output logic        mask_data_ack,
    input  logic        coe_localfreeze,
    input  logic        coe_globalfreeze,
    input  logic        coe_enable,
    input  logic [1:0]  avs_result_address,
    input  logic        avs_result_read,
    input  logic        avs_result_write,
    input  logic [31:0] avs_result_writedata,
    output logic [31:0] avs_result_readdata,
    output logic        avs_result_readdatavalid,
    output logic        coe_not_empty
);

    localparam logic [AW:0]   DEPTH_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [31:0]   accepted;
    logic [31:0]   stalls;

    logic          frozen;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          flush;
    logic          clear;
    logic          stall;
    logic [31:0]   read_value;
    logic          unused_writedata;

    assign frozen        = coe_globalfreeze & coe_localfreeze;
    assign full          = (count == DEPTH_COUNT);
    assign empty         = (count == '0);
    assign accept        = coe_enable & ~frozen & ~full;
    assign mask_data_ack = mask_data_valid & accept;
    assign push          = mask_data_valid & mask_data_ack;
    assign pop           = avs_result_read & (avs_result_address == 2'd0) & ~empty;
    assign flush         = avs_result_write & (avs_result_address == 2'd1) & avs_result_writedata[0];
    assign clear         = avs_result_write & (avs_result_address == 2'd3) & avs_result_writedata[0];
    assign stall         = mask_data_valid & coe_enable & ~frozen & full;

    assign unused_writedata = ^avs_result_writedata[31:1];

    // Register-map read mux, evaluated on the state before the clock edge.
    always_comb begin
        read_value = '0;
        case (avs_result_address)
            2'd0: begin
                read_value[31] = ~empty;
                if (!empty) begin
                    read_value[9:0] = mem[rptr];
                end
            end
            2'd1: begin
                read_value[AW:0] = count;
                read_value[16]   = full;
                read_value[17]   = empty;
                read_value[18]   = frozen;
                read_value[19]   = coe_enable;
            end
            2'd2: read_value = accepted;
            default: read_value = stalls;
        endcase
    end

    // Storage array; a push that coincides with a flush is dropped.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wptr] <= mask_data_out;
        end
    end

    // FIFO pointers and occupancy, with flush taking priority over push/pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Statistics: accepted wraps, stall saturates, clear beats increment.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            accepted <= '0;
            stalls   <= '0;
        end else begin
            if (push) begin
                accepted <= accepted + 32'd1;
            end
            if (stall && (stalls != 32'hFFFF_FFFF)) begin
                stalls <= stalls + 32'd1;
            end
        end
    end

    // Registered Avalon read response and occupancy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            avs_result_readdata      <= '0;
            avs_result_readdatavalid <= 1'b0;
            coe_not_empty            <= 1'b0;
        end else begin
            avs_result_readdatavalid <= avs_result_read;
            if (avs_result_read) begin
                avs_result_readdata <= read_value;
            end
            coe_not_empty <= ~empty;
        end
    end

endmodule

// File: tb/tb_match_result_collector.sv
// tb_match_result_collector: directed scenarios for match_result_collector
// with hand-computed expected values and inline checks.
module tb_match_result_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  mask_data_out = '0;
    logic        mask_data_valid = 1'b0;
    logic        mask_data_ack;
    logic        coe_localfreeze = 1'b0;
    logic        coe_globalfreeze = 1'b0;
    logic        coe_enable = 1'b0;
    logic [1:0]  avs_result_address = '0;
    logic        avs_result_read = 1'b0;
    logic        avs_result_write = 1'b0;
    logic [31:0] avs_result_writedata = '0;
    logic [31:0] avs_result_readdata;
    logic        avs_result_readdatavalid;
    logic        coe_not_empty;

    int checks = 0;
    int errors = 0;

    match_result_collector #(.DEPTH(16), .AW(4)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .mask_data_out            (mask_data_out),
        .mask_data_valid          (mask_data_valid),
        .mask_data_ack            (mask_data_ack),
        .coe_localfreeze          (coe_localfreeze),
        .coe_globalfreeze         (coe_globalfreeze),
        .coe_enable               (coe_enable),
        .avs_result_address       (avs_result_address),
        .avs_result_read          (avs_result_read),
        .avs_result_write         (avs_result_write),
        .avs_result_writedata     (avs_result_writedata),
        .avs_result_readdata      (avs_result_readdata),
        .avs_result_readdatavalid (avs_result_readdatavalid),
        .coe_not_empty            (coe_not_empty)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // Single Avalon read; returns the response seen one cycle later.
    task automatic do_read(input logic [1:0] addr, output logic [31:0] data, output logic valid);
        @(negedge clock);
        avs_result_address = addr;
        avs_result_read    = 1'b1;
        @(negedge clock);
        avs_result_read    = 1'b0;
        data  = avs_result_readdata;
        valid = avs_result_readdatavalid;
    endtask

    // Single Avalon write.
    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clock);
        avs_result_address   = addr;
        avs_result_writedata = data;
        avs_result_write     = 1'b1;
        @(negedge clock);
        avs_result_write     = 1'b0;
        avs_result_writedata = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (mask_data_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", mask_data_ack); end
        checks++; if (avs_result_readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", avs_result_readdata); end
        checks++; if (avs_result_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdv got %b want 0", avs_result_readdatavalid); end
        checks++; if (coe_not_empty !== 1'b0) begin errors++; $display("[TB] FAIL reset_not_empty got %b want 0", coe_not_empty); end
    endtask

    task automatic test_push_pop;
        logic [9:0]  vals [3];
        logic [31:0] exp_pop [4];
        logic [31:0] d;
        logic        v;
        vals = '{10'h001, 10'h002, 10'h3FF};
        exp_pop = '{32'h8000_0001, 32'h8000_0002, 32'h8000_03FF, 32'h0000_0000};
        coe_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mask_data_valid = 1'b1;
            mask_data_out   = vals[i];
            #1;
            checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL push_ack[%0d] got %b want 1", i, mask_data_ack); end
        end
        @(negedge clock);
        mask_data_valid = 1'b0;
        checks++; if (coe_not_empty !== 1'b1) begin errors++; $display("[TB] FAIL push_not_empty got %b want 1", coe_not_empty); end
        for (int i = 0; i < 4; i++) begin
            do_read(2'd0, d, v);
            checks++; if (d !== exp_pop[i] || v !== 1'b1) begin errors++; $display("[TB] FAIL pop[%0d] got %h/%b want %h/1", i, d, v, exp_pop[i]); end
        end
        do_read(2'd2, d, v);
        checks++; if (d !== 32'd3) begin errors++; $display("[TB] FAIL accepted_after_3 got %0d want 3", d); end
        @(negedge clock);
        checks++; if (coe_not_empty !== 1'b0) begin errors++; $display("[TB] FAIL drained_not_empty got %b want 0", coe_not_empty); end
    endtask

    task automatic test_fill_stall;
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            mask_data_valid = 1'b1;
            mask_data_out   = 10'(i);
            #1;
            checks++; if (mask_data_ack !== (i < 16)) begin errors++; $display("[TB] FAIL fill_ack[%0d] got %b want %b", i, mask_data_ack, (i < 16)); end
        end
        @(negedge clock);
        mask_data_valid = 1'b0;
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h0009_0010) begin errors++; $display("[TB] FAIL full_status got %h want 00090010", d); end
        do_read(2'd3, d, v);
        checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL stall_count got %0d want 5", d); end
        do_read(2'd2, d, v);
        checks++; if (d !== 32'd19) begin errors++; $display("[TB] FAIL accepted_after_fill got %0d want 19", d); end
    endtask

    task automatic test_full_pop;
        logic [31:0] d;
        logic        v;
        @(negedge clock);
        mask_data_valid    = 1'b1;
        mask_data_out      = 10'h155;
        avs_result_address = 2'd0;
        avs_result_read    = 1'b1;
        #1;
        checks++; if (mask_data_ack !== 1'b0) begin errors++; $display("[TB] FAIL full_ack_before_pop got %b want 0", mask_data_ack); end
        @(negedge clock);
        avs_result_read = 1'b0;
        checks++; if (avs_result_readdata !== 32'h8000_0000 || avs_result_readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL full_pop got %h/%b want 80000000/1", avs_result_readdata, avs_result_readdatavalid); end
        #1;
        checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL ack_after_pop got %b want 1", mask_data_ack); end
        @(negedge clock);
        #1;
        checks++; if (mask_data_ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_refull got %b want 0", mask_data_ack); end
        mask_data_valid = 1'b0;
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h0009_0010) begin errors++; $display("[TB] FAIL refull_status got %h want 00090010", d); end
        do_read(2'd3, d, v);
        checks++; if (d !== 32'd6) begin errors++; $display("[TB] FAIL stall_after_pop got %0d want 6", d); end
    endtask

    task automatic test_freeze;
        logic [31:0] d;
        logic        v;
        do_read(2'd0, d, v);
        checks++; if (d !== 32'h8000_0001) begin errors++; $display("[TB] FAIL drain1 got %h want 80000001", d); end
        do_read(2'd0, d, v);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("[TB] FAIL drain2 got %h want 80000002", d); end
        @(negedge clock);
        coe_globalfreeze = 1'b1;
        coe_localfreeze  = 1'b1;
        mask_data_valid  = 1'b1;
        mask_data_out    = 10'h2AA;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (mask_data_ack !== 1'b0) begin errors++; $display("[TB] FAIL frozen_ack[%0d] got %b want 0", i, mask_data_ack); end
            @(negedge clock);
        end
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h000C_000E) begin errors++; $display("[TB] FAIL frozen_status got %h want 000C000E", d); end
        @(negedge clock);
        coe_globalfreeze = 1'b0;
        coe_localfreeze  = 1'b0;
        coe_enable       = 1'b0;
        #1;
        checks++; if (mask_data_ack !== 1'b0) begin errors++; $display("[TB] FAIL disabled_ack got %b want 0", mask_data_ack); end
        @(negedge clock);
        coe_enable       = 1'b1;
        coe_globalfreeze = 1'b1;
        #1;
        checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL half_freeze_ack0 got %b want 1", mask_data_ack); end
        @(negedge clock);
        mask_data_out = 10'h2AB;
        #1;
        checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL half_freeze_ack1 got %b want 1", mask_data_ack); end
        @(negedge clock);
        mask_data_valid = 1'b0;
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h0009_0010) begin errors++; $display("[TB] FAIL resumed_status got %h want 00090010", d); end
        coe_globalfreeze = 1'b0;
        do_read(2'd3, d, v);
        checks++; if (d !== 32'd6) begin errors++; $display("[TB] FAIL stall_frozen got %0d want 6", d); end
    endtask

    task automatic test_flush_clear;
        logic [31:0] d;
        logic        v;
        do_write(2'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            mask_data_valid = 1'b1;
            mask_data_out   = 10'h010 + 10'(i);
            #1;
            checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL flush_push_ack[%0d] got %b want 1", i, mask_data_ack); end
        end
        @(negedge clock);
        mask_data_valid = 1'b0;
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h0008_0004) begin errors++; $display("[TB] FAIL four_status got %h want 00080004", d); end
        do_write(2'd1, 32'd1);
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h000A_0000) begin errors++; $display("[TB] FAIL flushed_status got %h want 000A0000", d); end
        do_read(2'd0, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("[TB] FAIL flushed_pop got %h/%b want 00000000/1", d, v); end
        @(negedge clock);
        mask_data_valid      = 1'b1;
        mask_data_out        = 10'h123;
        avs_result_address   = 2'd1;
        avs_result_writedata = 32'd1;
        avs_result_write     = 1'b1;
        #1;
        checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL flush_push_ack got %b want 1", mask_data_ack); end
        @(negedge clock);
        mask_data_valid  = 1'b0;
        avs_result_write = 1'b0;
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h000A_0000) begin errors++; $display("[TB] FAIL flush_wins got %h want 000A0000", d); end
        do_read(2'd2, d, v);
        checks++; if (d !== 32'd27) begin errors++; $display("[TB] FAIL accepted_total got %0d want 27", d); end
        do_write(2'd3, 32'd1);
        do_read(2'd2, d, v);
        checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL accepted_cleared got %0d want 0", d); end
        do_read(2'd3, d, v);
        checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL stall_cleared got %0d want 0", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic        v;
        @(negedge clock);
        mask_data_valid    = 1'b1;
        mask_data_out      = 10'h0AB;
        avs_result_address = 2'd0;
        avs_result_read    = 1'b1;
        #1;
        checks++; if (mask_data_ack !== 1'b1) begin errors++; $display("[TB] FAIL empty_pop_push_ack got %b want 1", mask_data_ack); end
        @(negedge clock);
        mask_data_valid = 1'b0;
        checks++; if (avs_result_readdata !== 32'h0 || avs_result_readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL empty_pop got %h/%b want 00000000/1", avs_result_readdata, avs_result_readdatavalid); end
        @(negedge clock);
        avs_result_address = 2'd1;
        checks++; if (avs_result_readdata !== 32'h8000_00AB || avs_result_readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pop got %h/%b want 800000AB/1", avs_result_readdata, avs_result_readdatavalid); end
        @(negedge clock);
        avs_result_read = 1'b0;
        checks++; if (avs_result_readdata !== 32'h000A_0000 || avs_result_readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_status got %h/%b want 000A0000/1", avs_result_readdata, avs_result_readdatavalid); end
        @(negedge clock);
        checks++; if (avs_result_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rdv_idle got %b want 0", avs_result_readdatavalid); end
        do_read(2'd2, d, v);
        checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL accepted_b2b got %0d want 1", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            mask_data_valid = 1'b1;
            mask_data_out   = 10'(i);
        end
        @(negedge clock);
        mask_data_valid = 1'b0;
        @(negedge clock);
        checks++; if (coe_not_empty !== 1'b1) begin errors++; $display("[TB] FAIL seven_not_empty got %b want 1", coe_not_empty); end
        reset              = 1'b1;
        avs_result_address = 2'd1;
        avs_result_read    = 1'b1;
        @(negedge clock);
        reset           = 1'b0;
        avs_result_read = 1'b0;
        checks++; if (avs_result_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_rdv got %b want 0", avs_result_readdatavalid); end
        checks++; if (coe_not_empty !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_not_empty got %b want 0", coe_not_empty); end
        do_read(2'd1, d, v);
        checks++; if (d !== 32'h000A_0000) begin errors++; $display("[TB] FAIL reset_mid_status got %h want 000A0000", d); end
        do_read(2'd0, d, v);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_pop got %h want 00000000", d); end
        do_read(2'd2, d, v);
        checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_mid_accepted got %0d want 0", d); end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_push_pop();
        test_fill_stall();
        test_full_pop();
        test_freeze();
        test_flush_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
